elastic_pipe_reg: RTL

//  Parametrised pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, ...).

---
 rtl/elastic_pipe_reg_if.sv | 22 ++
 rtl/elastic_pipe_reg.sv | 117 +++++++++++
 2 files changed

// File: rtl/elastic_pipe_reg_if.sv
// Valid/ready handshake bundle for one elastic pipeline boundary.
// The slave side is the stage itself; the master side is its environment.
interface elastic_pipe_reg_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/elastic_pipe_reg.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer, flush-to-bubble,
// registered occupancy and a saturating back-pressure counter.
module elastic_pipe_reg #(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    elastic_pipe_reg_if.slave    ifc,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic [1:0]        occ_q, occ_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              acc, dq;

    assign ifc.in_ready  = in_ready_q;
    assign ifc.out_valid = (state_q != EMPTY);
    assign ifc.out_data  = main_q;
    assign occupancy     = occ_q;
    assign stall_cnt     = stall_q;

    assign acc = ifc.in_valid & in_ready_q;
    assign dq  = ifc.out_valid & ifc.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = ifc.in_data;
                    end
                end
                ONE: begin
                    if (acc && dq) begin
                        main_d = ifc.in_data;
                    end else if (acc) begin
                        state_d = FULL;
                        skid_d  = ifc.in_data;
                    end else if (dq) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the dequeue side can move
                    if (dq) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                end
            endcase
        end
    end

    always_comb begin
        in_ready_d = (state_d != FULL);
        unique case (state_d)
            ONE:     occ_d = 2'd1;
            FULL:    occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (ifc.out_valid && !ifc.out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= BUBBLE;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            occ_q      <= occ_d;
            stall_q    <= stall_d;
        end
    end

endmodule
